// File: rtl/plic_pkg.sv
// Shared register offsets and gateway state encoding for plic_lite.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package plic_pkg;

    localparam logic [11:0] PrioBase     = 12'h000;
    localparam logic [11:0] PendingOff   = 12'h080;
    localparam logic [11:0] EnableOff    = 12'h100;
    localparam logic [11:0] ThresholdOff = 12'h200;
    localparam logic [11:0] ClaimOff     = 12'h204;

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        Pending   = 2'd1,
        InService = 2'd2
    } gateway_state_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: latches a level request until claimed, then holds it until completed.
// Latency: irq to pending in 1 cycle; claim/complete take effect on the same edge.
// Backpressure: none; irq is ignored while pending or in service.
module plic_gateway
    import plic_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    gateway_state_t state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= Idle;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (irq) begin
                        state   <= Pending;
                        pending <= 1'b1;
                    end
                end
                Pending: begin
                    if (claim) begin
                        state      <= InService;
                        pending    <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                InService: begin
                    if (complete) begin
                        state      <= Idle;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= Idle;
                    pending    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/plic_lite.sv
// Lightweight PLIC: per-source priority/enable, global threshold, claim/complete over a register port.
// Latency: bus ack/rd_data 1 cycle after strobe; irq_src to external_interrupt 2 cycles.
// Backpressure: none; every strobe is acked next cycle, a write wins over a simultaneous read.
module plic_lite
    import plic_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int PRIO_WIDTH  = 3,
    parameter int DATA_SIZE   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [11:0]            addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   ack,
    output logic                   bus_error,
    output logic                   external_interrupt
);

    localparam int IdW = 5;

    logic [PRIO_WIDTH-1:0]  prio [1:NUM_SOURCES];
    logic [NUM_SOURCES:1]   enable;
    logic [PRIO_WIDTH-1:0]  threshold;
    logic [NUM_SOURCES:1]   pending;
    logic [NUM_SOURCES:1]   in_service;

    logic [11:0]            addr_w;
    logic [NUM_SOURCES:1]   prio_hit;
    logic                   hit_pend, hit_en, hit_thr, hit_claim, mapped;

    logic [IdW-1:0]         max_id;
    logic [PRIO_WIDTH-1:0]  max_prio;
    logic                   irq_above;
    logic                   claim_fire, complete_fire;
    logic [IdW-1:0]         claim_id, complete_id;
    logic [DATA_SIZE-1:0]   rd_mux;
    logic                   unused_bits;

    assign addr_w = {addr[11:2], 2'b00};

    always_comb begin
        prio_hit = '0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            prio_hit[i] = (addr_w == PrioBase + 12'(4 * i));
        end
    end

    assign hit_pend  = (addr_w == PendingOff);
    assign hit_en    = (addr_w == EnableOff);
    assign hit_thr   = (addr_w == ThresholdOff);
    assign hit_claim = (addr_w == ClaimOff);
    assign mapped    = (|prio_hit) | hit_pend | hit_en | hit_thr | hit_claim;

    // Strict '>' while scanning upward keeps the lowest ID on a priority tie
    // and excludes priority-0 sources for free.
    always_comb begin
        max_id   = '0;
        max_prio = '0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            if (pending[i] && enable[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
                max_id   = IdW'(i);
            end
        end
    end

    assign irq_above     = (max_prio > threshold);
    assign claim_fire    = rd_en && !wr_en && hit_claim;
    assign claim_id      = irq_above ? max_id : '0;
    assign complete_fire = wr_en && hit_claim;
    assign complete_id   = wr_data[IdW-1:0];

    for (genvar g = 1; g <= NUM_SOURCES; g++) begin : g_gw
        plic_gateway u_gw (
            .clock      (clock),
            .reset      (reset),
            .irq        (irq_src[g-1]),
            .claim      (claim_fire && (claim_id == IdW'(g))),
            .complete   (complete_fire && (complete_id == IdW'(g))),
            .pending    (pending[g]),
            .in_service (in_service[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            if (prio_hit[i]) rd_mux[PRIO_WIDTH-1:0] = prio[i];
        end
        if (hit_pend)  rd_mux[NUM_SOURCES:1]  = pending;
        if (hit_en)    rd_mux[NUM_SOURCES:1]  = enable;
        if (hit_thr)   rd_mux[PRIO_WIDTH-1:0] = threshold;
        if (hit_claim) rd_mux[IdW-1:0]        = claim_id;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= NUM_SOURCES; i++) prio[i] <= '0;
            enable             <= '0;
            threshold          <= '0;
            rd_data            <= '0;
            ack                <= 1'b0;
            bus_error          <= 1'b0;
            external_interrupt <= 1'b0;
        end else begin
            ack                <= rd_en | wr_en;
            bus_error          <= (rd_en | wr_en) && !mapped;
            rd_data            <= (rd_en && !wr_en) ? rd_mux : '0;
            external_interrupt <= irq_above;
            if (wr_en) begin
                for (int i = 1; i <= NUM_SOURCES; i++) begin
                    if (prio_hit[i]) prio[i] <= wr_data[PRIO_WIDTH-1:0];
                end
                if (hit_en)  enable    <= wr_data[NUM_SOURCES:1];
                if (hit_thr) threshold <= wr_data[PRIO_WIDTH-1:0];
            end
        end
    end

    assign unused_bits = ^{addr[1:0], wr_data, in_service};

endmodule

// File: tb/tb_plic_lite.sv
// Randomised and directed bench for plic_lite against a per-source behavioural model.
module tb_plic_lite;

    localparam int NS = 8;
    localparam int PW = 3;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NS-1:0] irq_src;
    logic          rd_en, wr_en;
    logic [11:0]   addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          ack, bus_error, external_interrupt;

    plic_lite #(.NUM_SOURCES(NS), .PRIO_WIDTH(PW), .DATA_SIZE(DW)) dut (
        .clock              (clock),
        .reset              (reset),
        .irq_src            (irq_src),
        .rd_en              (rd_en),
        .wr_en              (wr_en),
        .addr               (addr),
        .wr_data            (wr_data),
        .rd_data            (rd_data),
        .ack                (ack),
        .bus_error          (bus_error),
        .external_interrupt (external_interrupt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = idle, 1 = pending, 2 = in service
    int m_state [1:NS];
    int m_prio  [1:NS];
    int m_en    [1:NS];
    int m_thr;

    int addr_tab [12] = '{'h000, 'h004, 'h010, 'h020, 'h024, 'h080,
                          'h100, 'h200, 'h204, 'h300, 'h081, 'h07C};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 1; i <= NS; i++) begin
            m_state[i] = 0;
            m_prio[i]  = 0;
            m_en[i]    = 0;
        end
        m_thr = 0;
    endfunction

    // -1 unmapped, 1..NS priority id, 100 pending, 101 enable, 102 threshold, 103 claim
    function automatic int kind_of(input int a);
        int aw;
        aw = a & 'hFFC;
        if (aw >= 4 && aw <= 4 * NS) return aw / 4;
        if (aw == 'h080) return 100;
        if (aw == 'h100) return 101;
        if (aw == 'h200) return 102;
        if (aw == 'h204) return 103;
        return -1;
    endfunction

    function automatic int best_id();
        int bid, bp;
        bid = 0;
        bp  = 0;
        for (int i = 1; i <= NS; i++) begin
            if (m_state[i] == 1 && m_en[i] != 0 && m_prio[i] > bp) begin
                bp  = m_prio[i];
                bid = i;
            end
        end
        return bid;
    endfunction

    function automatic int pick_in_service();
        int s, i;
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 31);
        s = $urandom_range(1, NS);
        for (int j = 0; j < NS; j++) begin
            i = ((s - 1 + j) % NS) + 1;
            if (m_state[i] == 2) return i;
        end
        return 0;
    endfunction

    // One bus cycle, entered and left on a falling edge.
    task automatic cycle(input bit r, input bit w, input int a, input logic [31:0] d, output int rv);
        int k, win, wprio, cl, exp_rd;
        bit exp_err, exp_ext, do_claim, do_complete;
        rd_en   = r;
        wr_en   = w;
        addr    = a[11:0];
        wr_data = d;
        k       = kind_of(a);
        win     = best_id();
        wprio   = (win != 0) ? m_prio[win] : 0;
        cl      = (wprio > m_thr) ? win : 0;
        exp_ext = (wprio > m_thr);
        exp_err = (r || w) && (k < 0);
        exp_rd  = 0;
        if (k >= 1 && k <= NS) exp_rd = m_prio[k];
        else if (k == 100) begin
            for (int i = 1; i <= NS; i++) if (m_state[i] == 1) exp_rd |= (1 << i);
        end else if (k == 101) begin
            for (int i = 1; i <= NS; i++) if (m_en[i] != 0) exp_rd |= (1 << i);
        end else if (k == 102) exp_rd = m_thr;
        else if (k == 103) exp_rd = cl;
        do_claim    = r && !w && (k == 103);
        do_complete = w && (k == 103);

        @(posedge clock);
        #1;
        for (int i = 1; i <= NS; i++) begin
            if (m_state[i] == 1 && do_claim && cl == i) m_state[i] = 2;
            else if (m_state[i] == 2 && do_complete && int'(d[4:0]) == i) m_state[i] = 0;
            else if (m_state[i] == 0 && irq_src[i-1]) m_state[i] = 1;
        end
        if (w) begin
            if (k >= 1 && k <= NS) m_prio[k] = int'(d) & ((1 << PW) - 1);
            else if (k == 101) begin
                for (int i = 1; i <= NS; i++) m_en[i] = int'(d[i]);
            end else if (k == 102) m_thr = int'(d) & ((1 << PW) - 1);
        end
        check_eq("ack", 32'(ack), 32'(r | w));
        check_eq("bus_error", 32'(bus_error), 32'(exp_err));
        if (r && !w) check_eq("rd_data", rd_data, 32'(exp_rd));
        check_eq("ext_irq", 32'(external_interrupt), 32'(exp_ext));
        rv = int'(rd_data);
        @(negedge clock);
    endtask

    task automatic rd(input int a, output int v);
        cycle(1'b1, 1'b0, a, 32'h0, v);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        int dummy;
        cycle(1'b0, 1'b1, a, d, dummy);
    endtask

    task automatic idle();
        int dummy;
        cycle(1'b0, 1'b0, 0, 32'h0, dummy);
    endtask

    task automatic do_reset();
        rd_en = 1'b0;
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_bus_error", 32'(bus_error), 32'h0);
        check_eq("rst_rd_data", rd_data, 32'h0);
        check_eq("rst_ext", 32'(external_interrupt), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, op, id;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = '0;
        wr_data = '0;
        irq_src = '0;
        model_clear();
        #1;
        do_reset();

        // Reset readback
        rd('h080, v); check_eq("t1_pending", 32'(v), 32'h0);
        rd('h100, v); check_eq("t1_enable", 32'(v), 32'h0);
        rd('h200, v); check_eq("t1_thr", 32'(v), 32'h0);
        rd('h204, v); check_eq("t1_claim", 32'(v), 32'h0);

        // Single source: pend, interrupt, claim, complete, re-pend
        wr('h00C, 32'd2);
        wr('h100, 32'h08);
        wr('h200, 32'd1);
        irq_src[2] = 1'b1;
        idle();
        check_eq("t2_ext_lag", 32'(external_interrupt), 32'h0);
        rd('h080, v);
        check_eq("t2_pending", 32'(v), 32'h08);
        check_eq("t2_ext_on", 32'(external_interrupt), 32'h1);
        rd('h204, v); check_eq("t2_claim", 32'(v), 32'd3);
        idle();
        check_eq("t2_ext_off", 32'(external_interrupt), 32'h0);
        wr('h204, 32'd3);
        idle();
        rd('h080, v); check_eq("t2_repend", 32'(v), 32'h08);
        do_reset();

        // Priority order and tie-break
        wr('h008, 32'd5);
        wr('h014, 32'd5);
        wr('h018, 32'd7);
        wr('h100, 32'h64);
        irq_src = 8'b0011_0010;
        idle();
        idle();
        rd('h204, v); check_eq("t3_claim_a", 32'(v), 32'd6);
        rd('h204, v); check_eq("t3_claim_b", 32'(v), 32'd2);
        rd('h204, v); check_eq("t3_claim_c", 32'(v), 32'd5);
        rd('h204, v); check_eq("t3_claim_d", 32'(v), 32'd0);
        irq_src = '0;
        do_reset();

        // Threshold boundary: priority equal to threshold does not interrupt
        wr('h200, 32'd5);
        wr('h010, 32'd5);
        wr('h100, 32'h10);
        irq_src = 8'b0000_1000;
        idle();
        idle();
        check_eq("t4_ext_eq", 32'(external_interrupt), 32'h0);
        rd('h204, v); check_eq("t4_claim_eq", 32'(v), 32'd0);
        wr('h200, 32'd4);
        idle();
        check_eq("t4_ext_on", 32'(external_interrupt), 32'h1);
        rd('h204, v); check_eq("t4_claim", 32'(v), 32'd4);

        // Bogus completes and unmapped access
        wr('h204, 32'd7);
        check_eq("t5_err_id7", 32'(bus_error), 32'h0);
        wr('h204, 32'd0);
        check_eq("t5_err_id0", 32'(bus_error), 32'h0);
        rd('h080, v); check_eq("t5_pending", 32'(v), 32'h0);
        rd('h300, v);
        check_eq("t5_unmapped_data", 32'(v), 32'h0);
        check_eq("t5_unmapped_err", 32'(bus_error), 32'h1);
        wr('h204, 32'd4);
        idle();
        rd('h080, v); check_eq("t5_repend", 32'(v), 32'h10);
        cycle(1'b1, 1'b1, 'h200, 32'd3, v);
        rd('h200, v); check_eq("t5_rdwr_thr", 32'(v), 32'd3);
        irq_src = '0;
        do_reset();

        // Reset while source 1 is in service and a read is in flight
        wr('h004, 32'd3);
        wr('h008, 32'd2);
        wr('h100, 32'h06);
        irq_src = 8'b0000_0011;
        idle();
        idle();
        rd('h204, v); check_eq("t6_claim", 32'(v), 32'd1);
        idle();
        check_eq("t6_ext_pre", 32'(external_interrupt), 32'h1);
        rd_en = 1'b1;
        addr  = 12'h080;
        @(posedge clock);
        #2;
        check_eq("t6_ack_pre", 32'(ack), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("t6_ack_drop", 32'(ack), 32'h0);
        check_eq("t6_ext_drop", 32'(external_interrupt), 32'h0);
        rd_en   = 1'b0;
        irq_src = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        rd('h080, v); check_eq("t6_pending", 32'(v), 32'h0);
        rd('h100, v); check_eq("t6_enable", 32'(v), 32'h0);
        idle();

        // Random traffic against the model
        wr('h100, 32'h1FE);
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 4) == 0) irq_src = NS'($urandom);
            op = $urandom_range(0, 9);
            case (op)
                0: idle();
                1: rd(addr_tab[$urandom_range(0, 11)], v);
                2, 9: rd('h204, v);
                3: begin
                    id = pick_in_service();
                    wr('h204, ($urandom & 32'hFFFF_FFE0) | 32'(id));
                end
                4: wr(4 * $urandom_range(1, NS), $urandom);
                5: wr('h100, $urandom);
                6: wr('h200, 32'($urandom_range(0, 4)));
                7: cycle(1'b1, 1'b1, addr_tab[$urandom_range(0, 11)], $urandom, v);
                default: wr(addr_tab[$urandom_range(0, 11)], $urandom);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
